leve1_id: RTL and testbench
===========================

Name: leve1_id

Overview:
Decode stage directly downstream of the instruction-fetch stage. It consumes the fetch stage's valid/ready stream of {PC, instruction} and absorbs backpressure with a one-entry skid buffer. It decodes RV64I fields, opcode class and sign-extended immediate, and presents a registered decode bundle to execute. An optional register scoreboard stalls RAW and WAW hazards against instructions still in flight.

Parameters:
XLEN, 64, datapath/PC width
NREG, 32, architectural integer registers tracked by the scoreboard

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-high reset
IFLUSH  input  1  redirect/flush; kills all held instructions this cycle
IVALID  input  1  fetch bundle valid
IREADY  output  1  decode can accept a bundle
IPC  input  XLEN  fetch PC
IINSTR  input  32  fetched instruction
OVALID  output  1  decode bundle valid
OREADY  input  1  execute accepts bundle
OPC  output  XLEN  PC of bundle
OINSTR  output  32  raw instruction
OCLASS  output  4  opcode class (op_class_t)
ORS1  output  5  rs1 index (0 if unused)
ORS2  output  5  rs2 index (0 if unused)
ORD  output  5  rd index (0 if no write)
OIMM  output  XLEN  sign-extended immediate (I/S/B/U/J per class, 0 for R-type)
OILLEGAL  output  1  instr[1:0]!=2'b11 or unknown major opcode
IWB_VALID  input  1  writeback retires a register write
IWB_RD  input  5  writeback destination

Behaviour:
- Reset (async, RST=1): OVALID=0, skid empty, scoreboard all-clear. Other output data regs are don't-care. IREADY=1 the first cycle after RST deasserts.
- IREADY = !skid_valid (registered state only; no combinational path from OREADY).
- Head entry = skid if skid_valid, else the input bundle.
- Decode is combinational on the head entry and is registered into the output bundle.
- out_load = head_valid && !hazard && (!OVALID || OREADY) && !IFLUSH. On out_load, the output regs take the decoded head and OVALID=1.
- If OVALID && OREADY && !out_load: OVALID<=0.
- Skid fill: an input accepted (IVALID&&IREADY) that is not consumed into the output regs in the same cycle goes to skid. If the skid is the head and it loads, the skid empties. This gives throughput of 1/cycle and a decode-to-output latency of 1 cycle.
- Handshake: OPC..OILLEGAL are stable while OVALID && !OREADY.
- IFLUSH: next cycle OVALID=0 and skid empty. Any IVALID bundle in the flush cycle is dropped. An OVALID&&OREADY in the flush cycle is not an issue, and downstream ignores it.
- Field rules:
  - ORS1 is zero for LUI/AUIPC/JAL.
  - ORS2 is nonzero only for BRANCH/STORE/OP/OP32.
  - ORD is zero for BRANCH/STORE/MISCMEM/ILLEGAL.
  - Immediates are built at 32 bits and sign-extended from bit 31 to XLEN. U-type is {instr[31:12],12'b0} sign-extended.
- OILLEGAL=1 forces OCLASS=CL_ILLEGAL, ORS1=ORS2=ORD=0. It is never a stall source.
- hazard=0 when the scoreboard is compiled out.

Optional Feature:
LEVE1_ID_SCOREBOARD_EN
- Defined:
  - An NREG-bit pending vector is kept.
  - Issue = OVALID&&OREADY&&!IFLUSH. On issue with ORD!=0, set sb[ORD].
  - IWB_VALID clears sb[IWB_RD]. If set and clear hit the same index in one cycle, set wins.
  - Bit 0 is never set.
  - hazard = head's nonzero rs1/rs2/rd pending in sb, or equal to ORD of a valid output bundle.
  - IFLUSH does not alter sb, because issued instructions still write back.
- Not defined: no scoreboard logic; hazard tied 0; IWB_* unused.

Decomposition:
- Package leve1_pkg holds:
  - op_class_t enum: CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH, CL_LOAD, CL_STORE, CL_OPIMM, CL_OP, CL_OPIMM32, CL_OP32, CL_MISCMEM, CL_SYSTEM, CL_ILLEGAL.
  - RV major-opcode localparams.
  - dec_t packed struct {pc, instr, cls, rs1, rs2, rd, imm, illegal}.
- One natural combinational sub-module: leve1_id_dec (instr, pc -> dec_t), reused by later stages/tests.

Test Plan:
- Stream ADDI x1,x0,5 (0x00500093) @0x80000000 with OREADY=1 -> next cycle OVALID=1, OCLASS=CL_OPIMM, ORD=1, ORS1=0, OIMM=5.
- Back-to-back 4 instrs, OREADY low 2 cycles mid-stream -> IREADY drops exactly one cycle after skid fills, no loss/duplication, PCs in order.
- JAL x0,-4 (0xFFDFF06F) -> OCLASS=CL_JAL, ORD=0, OIMM=0xFFFF_FFFF_FFFF_FFFC; instr 0x00000013 with bits[1:0]=00 variant -> OILLEGAL=1.
- IFLUSH while skid and output both full -> following cycle OVALID=0, IREADY=1, no flushed PC ever appears with OVALID.
- (SCOREBOARD_EN) ADD x3,x1,x2 then ADD x4,x3,x3 -> second held (OVALID=0) until IWB_VALID with IWB_RD=3, issued the cycle after.
- RST asserted mid-stream with skid full -> OVALID=0 immediately (async), scoreboard clear, IREADY=1 after release.

Source files
------------

// File: rtl/leve1_id_pkg.sv
// Shared types for the leve1 decode stage: opcode classes, RV major opcodes and the decode bundle.
package leve1_pkg;

    localparam int XLEN_P = 64;

    typedef enum logic [3:0] {
        CL_LUI     = 4'd0,
        CL_AUIPC   = 4'd1,
        CL_JAL     = 4'd2,
        CL_JALR    = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_LOAD    = 4'd5,
        CL_STORE   = 4'd6,
        CL_OPIMM   = 4'd7,
        CL_OP      = 4'd8,
        CL_OPIMM32 = 4'd9,
        CL_OP32    = 4'd10,
        CL_MISCMEM = 4'd11,
        CL_SYSTEM  = 4'd12,
        CL_ILLEGAL = 4'd13
    } op_class_t;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM32   = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    typedef struct packed {
        logic [XLEN_P-1:0] pc;
        logic [31:0]       instr;
        op_class_t         cls;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN_P-1:0] imm;
        logic              illegal;
    } dec_t;

    function automatic logic [XLEN_P-1:0] sext32(input logic [31:0] v);
        return {{(XLEN_P-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/leve1_id_dec.sv
// Combinational RV64I decoder: {pc, instr} -> dec_t with class, register fields and immediate.
module leve1_id_dec
    import leve1_pkg::*;
(
    input  logic [XLEN_P-1:0] pc_i,
    input  logic [31:0]       instr_i,
    output dec_t              dec_o
);

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    op_class_t   cls;
    logic        legal, use_rs1, use_rs2, use_rd;

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        cls     = CL_ILLEGAL;
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        use_rd  = 1'b1;
        imm32   = imm_i;
        case (instr_i[6:0])
            OP_LUI:     begin cls = CL_LUI;     use_rs1 = 1'b0; imm32 = imm_u; end
            OP_AUIPC:   begin cls = CL_AUIPC;   use_rs1 = 1'b0; imm32 = imm_u; end
            OP_JAL:     begin cls = CL_JAL;     use_rs1 = 1'b0; imm32 = imm_j; end
            OP_JALR:    cls = CL_JALR;
            OP_BRANCH:  begin cls = CL_BRANCH;  use_rs2 = 1'b1; use_rd = 1'b0; imm32 = imm_b; end
            OP_LOAD:    cls = CL_LOAD;
            OP_STORE:   begin cls = CL_STORE;   use_rs2 = 1'b1; use_rd = 1'b0; imm32 = imm_s; end
            OP_IMM:     cls = CL_OPIMM;
            OP_OP:      begin cls = CL_OP;      use_rs2 = 1'b1; imm32 = '0; end
            OP_IMM32:   cls = CL_OPIMM32;
            OP_OP32:    begin cls = CL_OP32;    use_rs2 = 1'b1; imm32 = '0; end
            OP_MISCMEM: begin cls = CL_MISCMEM; use_rd = 1'b0; end
            OP_SYSTEM:  cls = CL_SYSTEM;
            default:    legal = 1'b0;
        endcase
        // compressed/reserved encodings (low bits != 11) never reach execute as valid ops
        if (instr_i[1:0] != 2'b11 || !legal) begin
            cls     = CL_ILLEGAL;
            legal   = 1'b0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
            imm32   = '0;
        end
    end

    assign dec_o = '{
        pc:      pc_i,
        instr:   instr_i,
        cls:     cls,
        rs1:     use_rs1 ? instr_i[19:15] : 5'd0,
        rs2:     use_rs2 ? instr_i[24:20] : 5'd0,
        rd:      use_rd  ? instr_i[11:7]  : 5'd0,
        imm:     sext32(imm32),
        illegal: !legal
    };

endmodule

// File: rtl/leve1_id.sv
// leve1 decode stage: skid-buffered fetch intake, RV64I decode, registered bundle to execute.
// Build option LEVE1_ID_SCOREBOARD_EN adds a RAW/WAW register scoreboard that stalls the head.
module leve1_id
    import leve1_pkg::*;
#(
    parameter int XLEN = XLEN_P,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IFLUSH,
    input  logic            IVALID,
    output logic            IREADY,
    input  logic [XLEN-1:0] IPC,
    input  logic [31:0]     IINSTR,
    output logic            OVALID,
    input  logic            OREADY,
    output logic [XLEN-1:0] OPC,
    output logic [31:0]     OINSTR,
    output logic [3:0]      OCLASS,
    output logic [4:0]      ORS1,
    output logic [4:0]      ORS2,
    output logic [4:0]      ORD,
    output logic [XLEN-1:0] OIMM,
    output logic            OILLEGAL,
    input  logic            IWB_VALID,
    input  logic [4:0]      IWB_RD
);

    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            out_valid_q, out_valid_d;
    dec_t            out_q, out_d, head_dec;
    logic            head_valid, hazard, accept, out_load;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;

    assign IREADY     = !skid_valid_q;
    assign accept     = IVALID && !skid_valid_q;
    assign head_valid = skid_valid_q || IVALID;
    assign head_pc    = skid_valid_q ? skid_pc_q : IPC;
    assign head_instr = skid_valid_q ? skid_instr_q : IINSTR;
    assign out_load   = head_valid && !hazard && (!out_valid_q || OREADY) && !IFLUSH;

    leve1_id_dec u_dec (
        .pc_i    (head_pc),
        .instr_i (head_instr),
        .dec_o   (head_dec)
    );

`ifdef LEVE1_ID_SCOREBOARD_EN
    logic [NREG-1:0] sb_q, sb_d;

    function automatic logic reg_busy(input logic [4:0] r, input logic [NREG-1:0] sb,
                                      input logic ov, input logic [4:0] ord);
        return (r != 5'd0) && (sb[r] || (ov && r == ord));
    endfunction

    assign hazard = reg_busy(head_dec.rs1, sb_q, out_valid_q, out_q.rd)
                 || reg_busy(head_dec.rs2, sb_q, out_valid_q, out_q.rd)
                 || reg_busy(head_dec.rd,  sb_q, out_valid_q, out_q.rd);

    // set after clear so an issue and a writeback to the same register leave it pending
    always_comb begin
        sb_d = sb_q;
        if (IWB_VALID) sb_d[IWB_RD] = 1'b0;
        if (out_valid_q && OREADY && !IFLUSH && out_q.rd != 5'd0) sb_d[out_q.rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sb_q <= '0;
        else     sb_q <= sb_d;
    end
`else
    logic unused_wb;
    assign hazard    = 1'b0;
    assign unused_wb = ^{IWB_VALID, IWB_RD} ^ (NREG > 0);
`endif

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (IFLUSH) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_load) skid_valid_d = 1'b0;
        end else if (accept && !out_load) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = IPC;
            skid_instr_d = IINSTR;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (IFLUSH) begin
            out_valid_d = 1'b0;
        end else if (out_load) begin
            out_valid_d = 1'b1;
            out_d       = head_dec;
        end else if (OREADY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
        end
    end

    assign OVALID   = out_valid_q;
    assign OPC      = out_q.pc;
    assign OINSTR   = out_q.instr;
    assign OCLASS   = out_q.cls;
    assign ORS1     = out_q.rs1;
    assign ORS2     = out_q.rs2;
    assign ORD      = out_q.rd;
    assign OIMM     = out_q.imm;
    assign OILLEGAL = out_q.illegal;

endmodule

// File: tb/tb_leve1_id.sv
// Self-checking bench for leve1_id: directed cases plus randomized streaming against a queue model.
`timescale 1ns/1ps
module tb_leve1_id;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IFLUSH, IVALID, IREADY, OVALID, OREADY, OILLEGAL, IWB_VALID;
    logic [63:0] IPC, OPC, OIMM;
    logic [31:0] IINSTR, OINSTR;
    logic [3:0]  OCLASS;
    logic [4:0]  ORS1, ORS2, ORD, IWB_RD;

    int total = 0;
    int bad   = 0;
    int n_issued = 0;

    typedef struct packed {
        logic [3:0]  cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t       q[$];
    logic [4:0] wbq[$];

    // class index order matches the opcode class list; format letter per class
    localparam logic [6:0] OPS [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                        7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};
    localparam logic [7:0] FMT [13] = '{"U", "U", "J", "I", "B", "I", "S",
                                        "I", "R", "I", "R", "I", "I"};

    leve1_id #(.XLEN(64), .NREG(32)) dut (
        .CLK(CLK), .RST(RST), .IFLUSH(IFLUSH), .IVALID(IVALID), .IREADY(IREADY),
        .IPC(IPC), .IINSTR(IINSTR), .OVALID(OVALID), .OREADY(OREADY), .OPC(OPC),
        .OINSTR(OINSTR), .OCLASS(OCLASS), .ORS1(ORS1), .ORS2(ORS2), .ORD(ORD),
        .OIMM(OIMM), .OILLEGAL(OILLEGAL), .IWB_VALID(IWB_VALID), .IWB_RD(IWB_RD)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model_dec(input logic [31:0] w);
        exp_t       e;
        int         k;
        logic [7:0] f;
        logic [31:0] imm;
        k = 13;
        for (int i = 0; i < 13; i++)
            if (w[1:0] == 2'b11 && w[6:0] == OPS[i]) k = i;
        e = '0;
        e.cls = 4'(k);
        if (k == 13) begin
            e.ill = 1'b1;
            return e;
        end
        f = FMT[k];
        case (f)
            "I":     imm = {{20{w[31]}}, w[31:20]};
            "S":     imm = {{20{w[31]}}, w[31:25], w[11:7]};
            "B":     imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            "U":     imm = {w[31:12], 12'b0};
            "J":     imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        e.imm = {{32{imm[31]}}, imm};
        e.rs1 = (f == "U" || f == "J") ? 5'd0 : w[19:15];
        e.rs2 = (f == "B" || f == "S" || f == "R") ? w[24:20] : 5'd0;
        e.rd  = (f == "B" || f == "S" || k == 11) ? 5'd0 : w[11:7];
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(9) == 0) return w;
        w[6:0]   = OPS[$urandom_range(12)];
        w[11:7]  = 5'($urandom_range(7));
        w[19:15] = 5'($urandom_range(7));
        w[24:20] = 5'($urandom_range(7));
        return w;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IVALID = 1'b0; IFLUSH = 1'b0; OREADY = 1'b0;
        IWB_VALID = 1'b0; IWB_RD = 5'd0; IPC = '0; IINSTR = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic drive_wb();
        if (wbq.size() > 0 && $urandom_range(9) < 4) begin
            IWB_VALID = 1'b1;
            IWB_RD    = wbq.pop_front();
        end else begin
            IWB_VALID = 1'b0;
            IWB_RD    = 5'($urandom_range(31));
        end
    endtask

    // reference: ordered list of accepted-but-not-issued bundles
    always @(posedge CLK or posedge RST) begin
        exp_t e;
        if (RST) begin
            q.delete();
            wbq.delete();
        end else if (IFLUSH) begin
            q.delete();
        end else begin
            if (OVALID && OREADY && q.size() > 0) begin
                e = model_dec(q[0].instr);
                if (e.rd != 5'd0) wbq.push_back(e.rd);
                void'(q.pop_front());
                n_issued++;
            end
            if (IVALID && IREADY) q.push_back('{IPC, IINSTR});
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            chk("depth_le2", q.size() <= 2, 1'b1);
            if (OVALID) begin
                chk("out_has_entry", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = model_dec(q[0].instr);
                    chk("bundle", {OPC, OINSTR, OCLASS, ORS1, ORS2, ORD, OIMM, OILLEGAL},
                        {q[0].pc, q[0].instr, e});
                end
            end
            if (q.size() == 0) chk("iready_empty", IREADY, 1'b1);
            if (q.size() == 2) chk("iready_full", IREADY, 1'b0);
`ifndef LEVE1_ID_SCOREBOARD_EN
            chk("ovalid_occ", OVALID, q.size() != 0);
            chk("iready_occ", IREADY, q.size() < 2);
`endif
        end
    end

    initial begin
        exp_t        e;
        int          n0;
        int          sent;
        logic [63:0] pc;

        e = model_dec(32'h00500093);
        chk("pin_addi", e, {4'd7, 5'd0, 5'd0, 5'd1, 64'd5, 1'b0});
        e = model_dec(32'hFFDFF06F);
        chk("pin_jal", e, {4'd2, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        e = model_dec(32'h00000010);
        chk("pin_ill", e, {4'd13, 15'd0, 64'd0, 1'b1});
        e = model_dec(32'hFE512C23);
        chk("pin_sw", e, {4'd6, 5'd2, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0});
        e = model_dec(32'h00208863);
        chk("pin_beq", e, {4'd4, 5'd1, 5'd2, 5'd0, 64'd16, 1'b0});
        e = model_dec(32'h800002B7);
        chk("pin_lui", e, {4'd0, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_8000_0000, 1'b0});

        do_reset();
        chk("rst_ovalid", OVALID, 1'b0);
        chk("rst_iready", IREADY, 1'b1);

        OREADY = 1'b1; IVALID = 1'b1; IPC = 64'h8000_0000; IINSTR = 32'h00500093;
        step();
        IVALID = 1'b0;
        chk("addi_ovalid", OVALID, 1'b1);
        chk("addi_class", OCLASS, 4'd7);
        chk("addi_rd", ORD, 5'd1);
        chk("addi_rs1", ORS1, 5'd0);
        chk("addi_imm", OIMM, 64'd5);
        chk("addi_pc", OPC, 64'h8000_0000);
        IVALID = 1'b1; IPC = 64'h8000_0004; IINSTR = 32'hFFDFF06F;
        step();
        chk("jal_class", OCLASS, 4'd2);
        chk("jal_rd", ORD, 5'd0);
        chk("jal_imm", OIMM, 64'hFFFF_FFFF_FFFF_FFFC);
        IPC = 64'h8000_0008; IINSTR = 32'h00000010;
        step();
        IVALID = 1'b0;
        chk("ill_flag", OILLEGAL, 1'b1);
        chk("ill_class", OCLASS, 4'd13);
        step();
        chk("ill_drained", OVALID, 1'b0);

        do_reset();
        n0 = n_issued;
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            OREADY = !(c == 2 || c == 3);
            IVALID = (sent < 4);
            IPC    = 64'h1000 + 64'(4 * sent);
            IINSTR = 32'h00000013 | (32'(sent + 1) << 7);
            if (c == 2) chk("stream_iready_before_fill", IREADY, 1'b1);
            if (c == 3) chk("stream_iready_after_fill", IREADY, 1'b0);
            if (c == 5) chk("stream_iready_recovered", IREADY, 1'b1);
            if (IVALID && IREADY) sent++;
            step();
        end
        idle();
        chk("stream_count", n_issued - n0, 4);

        do_reset();
        n0 = n_issued;
        IVALID = 1'b1; IPC = 64'h2000; IINSTR = 32'h00000013;
        step();
        IPC = 64'h2004;
        step();
        chk("flush_pre_iready", IREADY, 1'b0);
        chk("flush_pre_ovalid", OVALID, 1'b1);
        IFLUSH = 1'b1; OREADY = 1'b1; IPC = 64'h2008;
        step();
        IFLUSH = 1'b0; IVALID = 1'b0;
        chk("flush_ovalid", OVALID, 1'b0);
        chk("flush_iready", IREADY, 1'b1);
        repeat (4) step();
        chk("flush_no_issue", n_issued - n0, 0);

`ifdef LEVE1_ID_SCOREBOARD_EN
        do_reset();
        OREADY = 1'b1; IVALID = 1'b1; IPC = 64'h3000; IINSTR = 32'h002081B3;
        step();
        IPC = 64'h3004; IINSTR = 32'h00318233;
        step();
        IVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("sb_hold", OVALID, 1'b0);
            step();
        end
        IWB_VALID = 1'b1; IWB_RD = 5'd3;
        step();
        IWB_VALID = 1'b0;
        chk("sb_wb_edge", OVALID, 1'b0);
        step();
        chk("sb_issue", OVALID, 1'b1);
        chk("sb_issue_pc", OPC, 64'h3004);
        step();
`endif

        do_reset();
        IVALID = 1'b1; IPC = 64'h4000; IINSTR = 32'h00000013;
        step();
        IPC = 64'h4004;
        step();
        chk("rst_pre_skid", IREADY, 1'b0);
        RST = 1'b1;
        #1;
        chk("rst_async_ovalid", OVALID, 1'b0);
        idle();
        step();
        RST = 1'b0;
        step();
        chk("rst_rel_iready", IREADY, 1'b1);
        chk("rst_rel_ovalid", OVALID, 1'b0);

        do_reset();
        pc = 64'h8000_0000;
        for (int c = 0; c < 4000; c++) begin
            IVALID = ($urandom_range(9) < 7);
            OREADY = ($urandom_range(9) < 6);
            IFLUSH = ($urandom_range(99) < 3);
            if ($urandom_range(9) < 2) pc = {$urandom, $urandom} & ~64'h3;
            else pc = pc + 64'd4;
            IPC    = pc;
            IINSTR = gen_instr();
            drive_wb();
            step();
        end
        IVALID = 1'b0; IFLUSH = 1'b0; OREADY = 1'b1;
        for (int c = 0; c < 300 && (q.size() != 0 || OVALID); c++) begin
            drive_wb();
            step();
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_ovalid", OVALID, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
